// File: rtl/riscv_div_unit.sv
// riscv_div_unit
//   Iterative restoring divider for the RISC-V M extension (DIV/DIVU/REM/REMU).
//   Retires BITS_PER_CYCLE quotient bits per CALC cycle. Divide-by-zero,
//   signed overflow and (optionally) |b| > |a| complete without iterating.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous reset, ACTIVE HIGH despite the name
//   op_valid   issue request
//   op_ready   unit can accept this cycle (combinational from flush and state)
//   op_code    instruction word; only divide encodings are accepted
//   op_rd      destination register tag
//   op_a       dividend
//   op_b       divisor
//   flush      synchronous kill of any in-flight operation
//   busy       high while iterating (state CALC)
//   res_valid  one-cycle result strobe (the DONE cycle)
//   res_rd     tag of the completed operation
//   res_out    result, held until the next completion
module riscv_div_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned EARLY_OUT      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [31:0]     op_code,
  input  logic [4:0]      op_rd,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            res_valid,
  output logic [4:0]      res_rd,
  output logic [XLEN-1:0] res_out
);

  // RV32M R-type encodings: funct7=0000001, opcode=0110011, funct3 selects op
  localparam logic [31:0] INST_DIV_MASK = 32'hFE00707F;
  localparam logic [31:0] INST_DIV      = 32'h02004033;
  localparam logic [31:0] INST_DIVU     = 32'h02005033;
  localparam logic [31:0] INST_REM      = 32'h02006033;
  localparam logic [31:0] INST_REMU     = 32'h02007033;

  localparam int unsigned       N_ITER   = XLEN / BITS_PER_CYCLE;
  localparam int unsigned       CNT_W    = $clog2(N_ITER + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(N_ITER);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]   SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   rem_q, rem_d;     // partial remainder
  logic [XLEN-1:0]   quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0]   div_q, div_d;     // |divisor|
  logic              is_rem_q, is_rem_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   res_out_q, res_out_d;
  logic [4:0]        res_rd_q, res_rd_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;

  // Issue-side decode
  logic            dec_div, dec_divu, dec_rem, dec_remu;
  logic            any_div, op_signed, op_is_rem, accept;
  logic            a_neg, b_neg, b_zero, ovf, early, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  // Iteration datapath
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] rem_w, quo_w;
  logic [XLEN-1:0] q_fin, r_fin, calc_res;

  assign op_ready  = ~flush & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_rd    = res_rd_q;
  assign res_out   = res_out_q;

  always_comb begin
    dec_div   = (op_code & INST_DIV_MASK) == INST_DIV;
    dec_divu  = (op_code & INST_DIV_MASK) == INST_DIVU;
    dec_rem   = (op_code & INST_DIV_MASK) == INST_REM;
    dec_remu  = (op_code & INST_DIV_MASK) == INST_REMU;
    any_div   = dec_div | dec_divu | dec_rem | dec_remu;
    op_signed = dec_div | dec_rem;
    op_is_rem = dec_rem | dec_remu;
    accept    = op_valid & op_ready & any_div;

    a_neg  = op_signed & op_a[XLEN-1];
    b_neg  = op_signed & op_b[XLEN-1];
    // Magnitude of the signed minimum wraps to itself, which is 2^(XLEN-1) unsigned
    a_mag  = a_neg ? -op_a : op_a;
    b_mag  = b_neg ? -op_b : op_b;
    b_zero = (op_b == '0);
    ovf    = op_signed & (op_a == SMIN) & (op_b == '1);
    early  = (EARLY_OUT != 0) & (b_mag > a_mag);
    fast   = b_zero | ovf | early;

    if (b_zero)     fast_res = op_is_rem ? op_a : '1;
    else if (ovf)   fast_res = op_is_rem ? '0   : op_a;
    else            fast_res = op_is_rem ? op_a : '0;
  end

  // BITS_PER_CYCLE chained restoring steps from the registered state
  always_comb begin
    rem_w   = rem_q;
    quo_w   = quo_q;
    shifted = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {rem_w, quo_w[XLEN-1]};
      if (shifted >= {1'b0, div_q}) begin
        rem_w = XLEN'(shifted - {1'b0, div_q});
        quo_w = {quo_w[XLEN-2:0], 1'b1};
      end else begin
        rem_w = shifted[XLEN-1:0];
        quo_w = {quo_w[XLEN-2:0], 1'b0};
      end
    end
    q_fin    = neg_q_q ? -quo_w : quo_w;
    r_fin    = neg_r_q ? -rem_w : rem_w;
    calc_res = is_rem_q ? r_fin : q_fin;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    is_rem_d  = is_rem_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    rd_d      = rd_q;
    res_out_d = res_out_q;
    res_rd_d  = res_rd_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          is_rem_d = op_is_rem;
          rd_d     = op_rd;
          neg_q_d  = op_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]) & ~b_zero;
          neg_r_d  = a_neg;
          div_d    = b_mag;
          quo_d    = a_mag;
          rem_d    = '0;
          if (fast) begin
            state_d   = ST_DONE;
            res_out_d = fast_res;
            res_rd_d  = op_rd;
          end else begin
            state_d = ST_CALC;
            count_d = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          rem_d   = rem_w;
          quo_d   = quo_w;
          count_d = count_q - CNT_ONE;
          // Final iteration writes the result straight into the output register
          if (count_q == CNT_ONE) begin
            state_d   = ST_DONE;
            res_out_d = calc_res;
            res_rd_d  = rd_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d == ST_CALC);
    res_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      is_rem_q    <= 1'b0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      rd_q        <= '0;
      res_out_q   <= '0;
      res_rd_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      is_rem_q    <= is_rem_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      rd_q        <= rd_d;
      res_out_q   <= res_out_d;
      res_rd_q    <= res_rd_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed testbench for riscv_div_unit. Three instances share the operand
// inputs: default (K=1, early-out on), early-out off, and K=4.
// Latency is counted in clock edges with the accept edge counted as 1.
module tb_riscv_div_unit;

  localparam logic [31:0] C_DIV  = 32'h02C5C533;  // div x10,x11,x12
  localparam logic [31:0] C_DIVU = 32'h02005033;
  localparam logic [31:0] C_REM  = 32'h02006033;
  localparam logic [31:0] C_REMU = 32'h02007033;
  localparam logic [31:0] C_MUL  = 32'h02000033;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] code;
  logic [4:0]  rd;
  logic [31:0] a, b;
  logic        v0, v1, v2;

  logic        rdy0, busy0, rv0;
  logic        rdy1, busy1, rv1;
  logic        rdy2, busy2, rv2;
  logic [4:0]  rrd0, rrd1, rrd2;
  logic [31:0] rout0, rout1, rout2;

  logic        o_rdy, o_busy, o_rv;
  logic [4:0]  o_rd;
  logic [31:0] o_res;

  int tests = 0;
  int fails = 0;
  int cur   = 0;

  always #5 clk = ~clk;

  riscv_div_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1)) u_k1 (
    .clk(clk), .rst_n(rst), .op_valid(v0), .op_ready(rdy0), .op_code(code),
    .op_rd(rd), .op_a(a), .op_b(b), .flush(flush), .busy(busy0),
    .res_valid(rv0), .res_rd(rrd0), .res_out(rout0));

  riscv_div_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_OUT(0)) u_noeo (
    .clk(clk), .rst_n(rst), .op_valid(v1), .op_ready(rdy1), .op_code(code),
    .op_rd(rd), .op_a(a), .op_b(b), .flush(flush), .busy(busy1),
    .res_valid(rv1), .res_rd(rrd1), .res_out(rout1));

  riscv_div_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .EARLY_OUT(1)) u_k4 (
    .clk(clk), .rst_n(rst), .op_valid(v2), .op_ready(rdy2), .op_code(code),
    .op_rd(rd), .op_a(a), .op_b(b), .flush(flush), .busy(busy2),
    .res_valid(rv2), .res_rd(rrd2), .res_out(rout2));

  always_comb begin
    case (cur)
      1: begin o_rdy = rdy1; o_busy = busy1; o_rv = rv1; o_rd = rrd1; o_res = rout1; end
      2: begin o_rdy = rdy2; o_busy = busy2; o_rv = rv2; o_rd = rrd2; o_res = rout2; end
      default: begin o_rdy = rdy0; o_busy = busy0; o_rv = rv0; o_rd = rrd0; o_res = rout0; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; returns at the negedge of the DONE cycle.
  task automatic run_op(input int sel, input logic [31:0] c, input logic [4:0] t,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input int exp_lat,
                        input string tag, input bit chk_busy, input int exp_busy);
    int lat;
    int bc;
    bit done;
    cur  = sel;
    code = c; rd = t; a = x; b = y;
    v0 = (sel == 0); v1 = (sel == 1); v2 = (sel == 2);
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    lat = 1; bc = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (o_rv) begin
        done = 1'b1;
      end else begin
        if (o_busy) bc++;
        if (lat >= 200) begin
          done = 1'b1;
        end else begin
          @(posedge clk);
          lat++;
        end
      end
    end
    chk({tag, "_res"}, o_res, exp_res);
    chk({tag, "_rd"}, {27'b0, o_rd}, {27'b0, t});
    chk({tag, "_lat"}, lat, exp_lat);
    if (chk_busy) chk({tag, "_busy"}, bc, exp_busy);
  endtask

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; code = '0; rd = '0; a = '0; b = '0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy",  {31'b0, busy0}, 32'd0);
    chk("rst_valid", {31'b0, rv0},   32'd0);
    chk("rst_out",   rout0,          32'd0);
    chk("rst_rd",    {27'b0, rrd0},  32'd0);
    chk("rst_ready", {31'b0, rdy0},  32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Main function, default configuration
    run_op(0, C_DIV,  5'd5,  32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 33, "div_20_m3", 1'b1, 32);
    @(negedge clk);
    chk("single_pulse", {31'b0, rv0}, 32'd0);
    run_op(0, C_REM,  5'd6,  32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE, 33, "rem_m20_3",  1'b0, 0);
    run_op(0, C_REMU, 5'd7,  32'hFFFFFFFF,  32'h10,       32'h0000000F, 33, "remu_max",   1'b0, 0);
    run_op(0, C_DIVU, 5'd8,  32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 33, "divu_max_1", 1'b0, 0);
    run_op(0, C_DIV,  5'd9,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33, "div_m7_2",   1'b0, 0);
    run_op(0, C_REM,  5'd10, 32'd7,         32'hFFFFFFFE, 32'd1,        33, "rem_7_m2",   1'b0, 0);

    // Fast paths, issued back-to-back
    run_op(0, C_DIVU, 5'd11, 32'h1234,      32'd0,        32'hFFFFFFFF, 1, "divu_by0", 1'b0, 0);
    run_op(0, C_REM,  5'd12, 32'h80000005,  32'd0,        32'h80000005, 1, "rem_by0",  1'b0, 0);
    run_op(0, C_DIV,  5'd13, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1, "div_ovf",  1'b0, 0);
    run_op(0, C_REM,  5'd14, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1, "rem_ovf",  1'b0, 0);
    run_op(0, C_DIVU, 5'd15, 32'd5,         32'd7,        32'd0,        1, "divu_eo",  1'b0, 0);
    run_op(0, C_REMU, 5'd16, 32'd5,         32'd7,        32'd5,        1, "remu_eo",  1'b0, 0);

    // Early out disabled, and 4 bits per cycle
    @(negedge clk);
    run_op(1, C_DIVU, 5'd17, 32'd5,   32'd7, 32'd0,  33, "noeo_divu", 1'b0, 0);
    run_op(1, C_REMU, 5'd18, 32'd5,   32'd7, 32'd5,  33, "noeo_remu", 1'b0, 0);
    run_op(2, C_DIV,  5'd19, 32'd100, 32'd7, 32'd14, 9,  "k4_div",    1'b1, 8);
    @(negedge clk);
    cur = 0;

    // Non-divide op_code is not accepted
    code = C_MUL; a = 32'd100; b = 32'd7; rd = 5'd1; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy0 | rv0) seen++;
    end
    chk("nondiv_ignored", seen, 32'd0);

    // Flush on the 10th CALC cycle
    code = C_DIVU; a = 32'd1000; b = 32'd3; rd = 5'd2; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_busy_before", {31'b0, busy0}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", {31'b0, busy0}, 32'd0);
    chk("flush_ready_after", {31'b0, rdy0}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rv0) seen++;
    end
    chk("flush_no_result", seen, 32'd0);

    // Flush together with op_valid: no accept
    code = C_DIVU; a = 32'd100; b = 32'd7; rd = 5'd4; v0 = 1'b1; flush = 1'b1;
    #1;
    chk("flushvalid_ready", {31'b0, rdy0}, 32'd0);
    @(posedge clk); #1 v0 = 1'b0; flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy0 | rv0) seen++;
    end
    chk("flushvalid_no_accept", seen, 32'd0);

    // Back-to-back: second op issued in the DONE cycle of the first
    run_op(0, C_DIVU, 5'd3, 32'd100, 32'd7, 32'd14, 33, "b2b_first", 1'b0, 0);
    chk("b2b_ready_in_done", {31'b0, rdy0}, 32'd1);
    run_op(0, C_REMU, 5'd9, 32'd100, 32'd7, 32'd2,  33, "b2b_second", 1'b0, 0);

    // Reset mid-operation
    @(negedge clk);
    code = C_DIVU; a = 32'd999; b = 32'd5; rd = 5'd20; v0 = 1'b1;
    @(posedge clk); #1 v0 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rstmid_busy", {31'b0, busy0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rv0 | busy0) seen++;
    end
    chk("rstmid_no_result", seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
